// File: rtl/sum_pkg.sv
// sum_pkg: shared width default and FSM state encoding for the sum-of-N engine
package sum_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sum_up_counter_if.sv
// sum_up_counter_if: start/done handshake plus count and sum observation bus
interface sum_up_counter_if #(
    parameter int WIDTH     = sum_pkg::DEFAULT_WIDTH,
    parameter int SUM_WIDTH = 2 * WIDTH
);

    logic                 start;
    logic [WIDTH-1:0]     N;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     count;
    logic [SUM_WIDTH-1:0] sum;

    modport master (output start, N, input busy, done, count, sum);
    modport slave  (input start, N, output busy, done, count, sum);

endinterface

// File: rtl/sum_up_counter.sv
// sum_up_counter: counts 1..N after start and accumulates 1+2+..+N, pulsing done at the end
module sum_up_counter
    import sum_pkg::*;
#(
    parameter int WIDTH     = sum_pkg::DEFAULT_WIDTH,
    parameter int SUM_WIDTH = 2 * WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sum_up_counter_if.slave        bus
);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     n_q, n_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic [SUM_WIDTH-1:0] sum_q, sum_d;
    logic                 busy_q, done_q;
    logic [WIDTH:0]       inc;

    // Next-state logic for the FSM, counter and accumulator; the extra bit of inc keeps the compare exact
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        count_d = count_q;
        sum_d   = sum_q;
        inc     = {1'b0, count_q} + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    n_d     = bus.N;
                    count_d = '0;
                    sum_d   = '0;
                    state_d = (bus.N == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                count_d = inc[WIDTH-1:0];
                sum_d   = sum_q + SUM_WIDTH'(inc);
                state_d = (inc == {1'b0, n_q}) ? ST_DONE : ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; busy/done are registered from the next state so they track the state exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            count_q <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            busy_q  <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.count = count_q;
    assign bus.sum   = sum_q;

endmodule

// File: tb/tb_sum_up_counter.sv
// tb_sum_up_counter: randomized self-checking bench against an arithmetic sum-of-N model
module tb_sum_up_counter;

    localparam int W  = 4;
    localparam int SW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails = 0;

    sum_up_counter_if #(.WIDTH(W), .SUM_WIDTH(SW)) bus ();

    sum_up_counter #(.WIDTH(W), .SUM_WIDTH(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Full run of length n; after edge k of the run the model says count=k, sum=k(k+1)/2.
    // junk: 0 none, 1 random start/N while busy or done, 2 start with N=3 before edge 2
    task automatic run_sum(input int n, input int junk);
        logic [13:0] got, exp_v;
        bus.N = W'(n);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        got = {bus.busy, bus.done, bus.count, bus.sum};
        exp_v = {n != 0, n == 0, W'(0), SW'(0)};
        checks++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL run_accept n=%0d: got busy=%b done=%b count=%0d sum=%0d, want busy=%b done=%b count=0 sum=0",
                     n, got[13], got[12], got[11:8], got[7:0], exp_v[13], exp_v[12]);
        end
        for (int k = 1; k <= n; k++) begin
            if (junk == 1) begin
                bus.start = 1'($urandom);
                bus.N = W'($urandom);
            end else if (junk == 2 && k == 2) begin
                bus.start = 1'b1;
                bus.N = W'(3);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            got = {bus.busy, bus.done, bus.count, bus.sum};
            exp_v = {k < n, k == n, W'(k), SW'(k * (k + 1) / 2)};
            checks++;
            if (got !== exp_v) begin
                fails++;
                $display("FAIL run_step n=%0d k=%0d: got busy=%b done=%b count=%0d sum=%0d, want busy=%b done=%b count=%0d sum=%0d",
                         n, k, got[13], got[12], got[11:8], got[7:0], exp_v[13], exp_v[12], exp_v[11:8], exp_v[7:0]);
            end
        end
        if (junk == 1) begin
            bus.start = 1'($urandom);
            bus.N = W'($urandom);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        got = {bus.busy, bus.done, bus.count, bus.sum};
        exp_v = {1'b0, 1'b0, W'(n), SW'(n * (n + 1) / 2)};
        checks++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL run_idle n=%0d: got busy=%b done=%b count=%0d sum=%0d, want busy=0 done=0 count=%0d sum=%0d",
                     n, got[13], got[12], got[11:8], got[7:0], exp_v[11:8], exp_v[7:0]);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.N = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.count, bus.sum} !== 14'd0) begin
            fails++;
            $display("FAIL reset_init: got busy=%b done=%b count=%0d sum=%0d, want all 0",
                     bus.busy, bus.done, bus.count, bus.sum);
        end
        @(negedge clk) rst_n = 1'b1;
        bus.N = W'(9);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.count, bus.sum} !== 14'd0) begin
            fails++;
            $display("FAIL reset_async: got busy=%b done=%b count=%0d sum=%0d, want all 0",
                     bus.busy, bus.done, bus.count, bus.sum);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_sum(5, 0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.sum !== SW'(15) || bus.count !== W'(5) || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL basic_hold: got count=%0d sum=%0d busy=%b done=%b, want count=5 sum=15 busy=0 done=0",
                     bus.count, bus.sum, bus.busy, bus.done);
        end
    endtask

    task automatic test_zero();
        run_sum(0, 0);
    endtask

    task automatic test_max();
        run_sum(15, 0);
    endtask

    task automatic test_back_to_back();
        run_sum(6, 2);
        run_sum(3, 0);
    endtask

    task automatic test_reset_mid_run();
        bus.N = W'(8);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.count !== W'(3) || bus.sum !== SW'(6) || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL midrun_pre: got count=%0d sum=%0d busy=%b, want count=3 sum=6 busy=1",
                     bus.count, bus.sum, bus.busy);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.count, bus.sum} !== 14'd0) begin
            fails++;
            $display("FAIL midrun_reset: got busy=%b done=%b count=%0d sum=%0d, want all 0",
                     bus.busy, bus.done, bus.count, bus.sum);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                fails++;
                $display("FAIL midrun_nodone cycle=%0d: got busy=%b done=%b, want 0 0", i, bus.busy, bus.done);
            end
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_sum(2, 0);
    endtask

    task automatic test_random();
        int n, last_n, gap;
        last_n = 2;
        for (int r = 0; r < 25; r++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                checks++;
                if (bus.count !== W'(last_n) || bus.sum !== SW'(last_n * (last_n + 1) / 2) || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                    fails++;
                    $display("FAIL random_idle n=%0d: got count=%0d sum=%0d busy=%b done=%b, want count=%0d sum=%0d 0 0",
                             last_n, bus.count, bus.sum, bus.busy, bus.done, last_n, last_n * (last_n + 1) / 2);
                end
            end
            n = $urandom_range(0, 15);
            run_sum(n, 1);
            last_n = n;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_max();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
